// File: rtl/pc_branch_unit_16b.sv
// PC stage: holds the PC, forms branch/jump targets and drives a fixed-length flush window.
// Optional macro PC_BRANCH_RANGE_CHECK_EN builds the sticky branch wrap-around flag range_err.
module pc_branch_unit_16b #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [16:0] branch_offset,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        flush,
  output logic        redirect,
  output logic        align_err,
  output logic        range_err
);

  typedef enum logic [1:0] {StRst, StRun, StFlush} state_e;

  localparam logic [2:0] CntLoad = 3'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] pc_q;
  logic        flush_q;
  logic        redirect_q;
  logic        align_err_q;
  logic [15:0] seq_target;
  logic [15:0] branch_target;

  assign seq_target = pc_q + 16'd2;

`ifdef PC_BRANCH_RANGE_CHECK_EN
  // Zero-extended PC plus sign-extended offset: bit 16 set means the target wrapped.
  logic [16:0] branch_sum;
  logic        take_branch;
  logic        range_err_q;

  assign branch_sum    = {1'b0, pc_q} + branch_offset;
  assign branch_target = branch_sum[15:0];
  assign take_branch   = !stall && (state_q == StRun) && !jump && branch_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err_q <= 1'b0;
    end else if (take_branch && branch_sum[16]) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  logic unused_offset_sign;

  assign branch_target      = pc_q + branch_offset[15:0];
  assign unused_offset_sign = branch_offset[16];
  assign range_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRst;
      cnt_q       <= 3'd0;
      pc_q        <= RESET_VECTOR;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StRst: begin
          state_q <= StRun;
          pc_q    <= seq_target;
        end
        StRun: begin
          if (jump || branch_taken) begin
            pc_q       <= jump ? {jump_addr[15:1], 1'b0} : branch_target;
            state_q    <= StFlush;
            cnt_q      <= CntLoad;
            flush_q    <= 1'b1;
            redirect_q <= 1'b1;
            if (jump && jump_addr[0]) begin
              align_err_q <= 1'b1;
            end
          end else begin
            pc_q <= seq_target;
          end
        end
        StFlush: begin
          // Requests arriving here are dropped; upstream re-issues after the window.
          pc_q       <= seq_target;
          redirect_q <= 1'b0;
          if (cnt_q == 3'd0) begin
            state_q <= StRun;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= StRst;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign pc_plus2  = seq_target;
  assign flush     = flush_q;
  assign redirect  = redirect_q;
  assign align_err = align_err_q;

endmodule
